// File: rtl/sha256_msg_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_feeder_if
//  Description : Bundle of the SHA-256 feeder's message-side and core-side
//                signals.
//                slave  : feeder side (sha256_msg_feeder)
//                master : environment side (message source + block core)
//  Signals     : msg_start, msg_len, in_valid, in_ready, in_data   (message)
//                blk_start, blk_data, h_chain, blk_done, blk_hash  (core)
//                digest, digest_valid                              (result)
//                blk_count (only with SHA256_FEEDER_CNT_EN)
//  Options     : SHA256_FEEDER_CNT_EN adds blk_count
//  Revision    : 1.0  initial release
// ============================================================================
interface sha256_msg_feeder_if #(
   parameter int LEN_W = 16
);
   logic                   msg_start;
   logic [LEN_W-1:0]       msg_len;
   logic                   in_valid;
   logic                   in_ready;
   logic [31:0]            in_data;
   logic                   blk_start;
   logic [0:15][31:0]      blk_data;
   logic [0:7][31:0]       h_chain;
   logic                   blk_done;
   logic [0:7][31:0]       blk_hash;
   logic [0:7][31:0]       digest;
   logic                   digest_valid;
`ifdef SHA256_FEEDER_CNT_EN
   logic [LEN_W-1:0]       blk_count;
`endif

   modport slave (
`ifdef SHA256_FEEDER_CNT_EN
      output blk_count,
`endif
      input  msg_start, msg_len, in_valid, in_data, blk_done, blk_hash,
      output in_ready, blk_start, blk_data, h_chain, digest, digest_valid
   );

   modport master (
`ifdef SHA256_FEEDER_CNT_EN
      input  blk_count,
`endif
      output msg_start, msg_len, in_valid, in_data, blk_done, blk_hash,
      input  in_ready, blk_start, blk_data, h_chain, digest, digest_valid
   );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_feeder
//  Description : SHA-256 front end. Takes a word-aligned 32-bit message
//                stream, appends the 0x80000000 pad word, zero fill and the
//                64-bit bit length, issues 512-bit blocks to one block core,
//                chains each returned hash into the next h_init and holds the
//                final digest.
//  Ports       : clk      - clock, all logic on posedge
//                reset_n  - asynchronous active-low reset
//                bus      - sha256_msg_feeder_if.slave (message stream,
//                           core handshake, digest)
//  Options     : SHA256_FEEDER_CNT_EN adds bus.blk_count (blocks issued in
//                the current message)
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_msg_feeder #(
   parameter int LEN_W = 16
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   sha256_msg_feeder_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [0:7][31:0] C_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [31:0] C_PAD_WORD = 32'h8000_0000;

   state_t              r_state;
   state_t              w_next;

   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_msg_idx;      // message words taken so far
   logic [3:0]          r_slot;         // slot within the block being filled
   logic                r_pad_done;     // pad word already placed
   logic                r_last;         // current block carries the length
   logic [0:15][31:0]   r_blk;
   logic [0:7][31:0]    r_h_chain;
   logic [0:7][31:0]    r_digest;
   logic                r_digest_valid;

   logic                w_in_ready;
   logic                w_write;
   logic [31:0]         w_word;
   logic                w_place_pad;
   logic                w_start_msg;
   logic                w_accept_done;
   logic [63:0]         w_bitlen;

   assign w_bitlen = {{(59-LEN_W){1'b0}}, r_len, 5'b00000};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and per-cycle slot content
   // ------------------------------------------------------------------
   always_comb begin
      w_next        = r_state;
      w_in_ready    = 1'b0;
      w_write       = 1'b0;
      w_word        = 32'h0;
      w_place_pad   = 1'b0;
      w_start_msg   = 1'b0;
      w_accept_done = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.msg_start) begin
               w_start_msg = 1'b1;
               w_next      = ST_FILL;
            end
         end
         ST_FILL: begin
            if (r_msg_idx < r_len) begin
               // Message words: slot advances only on a handshake.
               w_in_ready = 1'b1;
               if (bus.in_valid) begin
                  w_write = 1'b1;
                  w_word  = bus.in_data;
               end
            end else if (!r_pad_done) begin
               w_write     = 1'b1;
               w_word      = C_PAD_WORD;
               w_place_pad = 1'b1;
            end else begin
               // Zero fill; the length block ends with the 64-bit bit count.
               w_write = 1'b1;
               if (r_last && (r_slot == 4'd14)) begin
                  w_word = w_bitlen[63:32];
               end else if (r_last && (r_slot == 4'd15)) begin
                  w_word = w_bitlen[31:0];
               end
            end
            if (w_write && (r_slot == 4'd15)) begin
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.blk_done) begin
               w_accept_done = 1'b1;
               w_next        = r_last ? ST_DONE : ST_FILL;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len          <= '0;
         r_msg_idx      <= '0;
         r_slot         <= 4'd0;
         r_pad_done     <= 1'b0;
         r_last         <= 1'b0;
         r_blk          <= '0;
         r_h_chain      <= '0;
         r_digest       <= '0;
         r_digest_valid <= 1'b0;
      end else begin
         if (w_start_msg) begin
            r_len          <= bus.msg_len;
            r_msg_idx      <= '0;
            r_slot         <= 4'd0;
            r_pad_done     <= 1'b0;
            r_last         <= 1'b0;
            r_h_chain      <= C_IV;
            r_digest_valid <= 1'b0;
         end
         if (w_write) begin
            r_blk[r_slot] <= w_word;
            r_slot        <= r_slot + 4'd1;   // wraps 15 -> 0 at block end
         end
         if (w_in_ready && bus.in_valid) begin
            r_msg_idx <= r_msg_idx + LEN_W'(1);
         end
         if (w_place_pad) begin
            r_pad_done <= 1'b1;
            // Pad in slot 13 or lower leaves slots 14/15 free for the
            // length; otherwise a further all-pad block carries it.
            if (r_slot <= 4'd13) begin
               r_last <= 1'b1;
            end
         end
         if (w_accept_done) begin
            r_h_chain <= bus.blk_hash;
            if (r_last) begin
               r_digest       <= bus.blk_hash;
               r_digest_valid <= 1'b1;
            end else begin
               // Pad already placed but no room for the length: the next
               // block is the final all-pad block.
               r_last <= r_pad_done;
            end
         end
      end
   end

`ifdef SHA256_FEEDER_CNT_EN
   logic [LEN_W-1:0] r_blk_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blk_count <= '0;
      end else if (w_start_msg) begin
         r_blk_count <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_blk_count <= r_blk_count + LEN_W'(1);
      end
   end

   assign bus.blk_count = r_blk_count;
`endif

   assign bus.in_ready     = w_in_ready;
   assign bus.blk_start    = (r_state == ST_ISSUE);
   assign bus.blk_data     = r_blk;
   assign bus.h_chain      = r_h_chain;
   assign bus.digest       = r_digest;
   assign bus.digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_feeder
//  Description : Self-checking bench for sha256_msg_feeder. Contains a
//                behavioural SHA-256 block core answering blk_start and a
//                software padding/hash model for expected values.
//  Options     : SHA256_FEEDER_CNT_EN also checks blk_count
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_msg_feeder;

   localparam int LEN_W = 16;

   typedef logic [0:7][31:0] hv_t;

   localparam hv_t C_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] C_DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] C_DIG_ABCD  = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

   logic clk;
   logic reset_n;
   logic core_done;
   logic man_done;
   logic core_en;
   int   core_lat;

   int   n_cmp;
   int   n_bad;
   int   acc;
   int   overrun;

   logic [31:0]  exp_w [$];
   logic [511:0] seen_blk [$];
   hv_t          last_hash;

   sha256_msg_feeder_if #(.LEN_W(LEN_W)) bus ();

   sha256_msg_feeder #(.LEN_W(LEN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   assign bus.blk_done = core_done | man_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Checking and SHA-256 model
   // ------------------------------------------------------------------
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic hv_t sha_compress(input hv_t h, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h[0]+a, h[1]+b, h[2]+c, h[3]+d, h[4]+e, h[5]+f, h[6]+g, h[7]+hh};
   endfunction

   function automatic logic [31:0] msg_word(input logic [31:0] base, input int i);
      return base + 32'(i) * 32'h01010101;
   endfunction

   // Standard SHA-256 padding of a word-aligned message.
   task automatic build_exp(input int len, input logic [31:0] base);
      exp_w.delete();
      for (int i = 0; i < len; i++) exp_w.push_back(msg_word(base, i));
      exp_w.push_back(32'h8000_0000);
      while ((exp_w.size() % 16) != 14) exp_w.push_back(32'h0);
      exp_w.push_back(32'h0);
      exp_w.push_back(32'(len * 32));
   endtask

   function automatic logic [511:0] exp_block(input int k);
      logic [511:0] blk;
      blk = '0;
      for (int i = 0; i < 16; i++) blk = {blk[479:0], exp_w[16*k + i]};
      return blk;
   endfunction

   function automatic hv_t model_digest();
      hv_t h;
      h = C_IV;
      for (int k = 0; k < exp_w.size() / 16; k++) h = sha_compress(h, exp_block(k));
      return h;
   endfunction

   function automatic logic [31:0] wsel(input logic [511:0] blk, input int k);
      return blk[511-32*k -: 32];
   endfunction

   // ------------------------------------------------------------------
   // Behavioural block core
   // ------------------------------------------------------------------
   initial begin : core_model
      logic [511:0] cap_blk;
      hv_t          cap_h;
      hv_t          exp_h;
      bit           stable;
      core_done    = 1'b0;
      bus.blk_hash = '0;
      forever begin
         @(posedge clk); #1;
         if (core_en && bus.blk_start) begin
            cap_blk = bus.blk_data;
            cap_h   = bus.h_chain;
            exp_h   = (seen_blk.size() == 0) ? C_IV : last_hash;
            chk("h_chain_at_issue", cap_h, exp_h);
            seen_blk.push_back(cap_blk);
            stable = 1'b1;
            repeat (core_lat) begin
               @(posedge clk); #1;
               if (bus.blk_data !== cap_blk || bus.h_chain !== cap_h) stable = 1'b0;
            end
            chk("blk_stable_in_wait", stable, 1'b1);
            last_hash    = sha_compress(cap_h, cap_blk);
            bus.blk_hash = last_hash;
            core_done    = 1'b1;
            @(posedge clk); #1;
            core_done    = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Message source
   // ------------------------------------------------------------------
   task automatic run_msg(input int len, input logic [31:0] base, input bit rnd, input bit interfere);
      int cyc;
      bit hit;
      build_exp(len, base);
      seen_blk.delete();
      acc = 0; overrun = 0; cyc = 0;
      @(posedge clk); #1;
      bus.msg_start = 1'b1;
      bus.msg_len   = LEN_W'(len);
      @(posedge clk); #1;
      bus.msg_start = 1'b0;
      while (!bus.digest_valid && cyc < 4000) begin
         bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : (acc < len);
         bus.in_data  = (acc < len) ? msg_word(base, acc) : 32'hdead_beef;
         if (interfere && cyc == 5) begin
            bus.msg_start = 1'b1;
            bus.msg_len   = LEN_W'(5);
            man_done      = 1'b1;
         end else begin
            bus.msg_start = 1'b0;
            man_done      = 1'b0;
         end
         if (bus.in_ready && acc >= len) overrun++;
         hit = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (hit) acc++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.msg_start = 1'b0;
      man_done      = 1'b0;
      chk("digest_valid_in_time", bus.digest_valid, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_in_ready"},     bus.in_ready, 1'b0);
      chk({tag, "_blk_start"},    bus.blk_start, 1'b0);
      chk({tag, "_digest_valid"}, bus.digest_valid, 1'b0);
      chk({tag, "_blk_data"},     bus.blk_data, '0);
      chk({tag, "_h_chain"},      bus.h_chain, '0);
      chk({tag, "_digest"},       bus.digest, '0);
`ifdef SHA256_FEEDER_CNT_EN
      chk({tag, "_blk_count"},    bus.blk_count, '0);
`endif
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   typedef struct {
      int           len;
      logic [31:0]  base;
      bit           rnd;
      int           nblk;
      bit           use_const;
      logic [255:0] dig;
   } vec_t;

   vec_t tbl [8];

   initial begin : main
      int  waited;
      bit  seen_start;
      hv_t dexp;

      tbl[0] = '{0,  32'h0000_0000, 1'b0, 1, 1'b1, C_DIG_EMPTY};
      tbl[1] = '{1,  32'h6162_6364, 1'b0, 1, 1'b1, C_DIG_ABCD};
      tbl[2] = '{13, 32'h1020_3040, 1'b0, 1, 1'b0, 256'h0};
      tbl[3] = '{14, 32'h1020_3040, 1'b0, 2, 1'b0, 256'h0};
      tbl[4] = '{20, 32'ha5a5_0000, 1'b1, 2, 1'b0, 256'h0};
      tbl[5] = '{16, 32'h0100_0000, 1'b0, 2, 1'b0, 256'h0};
      tbl[6] = '{29, 32'h0bad_f00d, 1'b1, 2, 1'b0, 256'h0};
      tbl[7] = '{30, 32'h1357_9bdf, 1'b0, 3, 1'b0, 256'h0};

      n_cmp = 0; n_bad = 0;
      reset_n = 1'b0;
      man_done = 1'b0;
      core_en = 1'b1;
      core_lat = 3;
      bus.msg_start = 1'b0;
      bus.msg_len = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;

      #2;
      check_outputs_zero("reset");
      #20 reset_n = 1'b1;

      // Table-driven messages
      for (int v = 0; v < 8; v++) begin
         core_lat = 2 + (v % 4);
         run_msg(tbl[v].len, tbl[v].base, tbl[v].rnd, 1'b0);
         dexp = tbl[v].use_const ? hv_t'(tbl[v].dig) : model_digest();
         chk($sformatf("v%0d_digest", v), bus.digest, dexp);
         chk($sformatf("v%0d_blocks", v), seen_blk.size(), tbl[v].nblk);
         chk($sformatf("v%0d_accepted", v), acc, tbl[v].len);
         chk($sformatf("v%0d_ready_overrun", v), overrun, 0);
`ifdef SHA256_FEEDER_CNT_EN
         chk($sformatf("v%0d_blk_count", v), bus.blk_count, tbl[v].nblk);
`endif
         for (int k = 0; k < seen_blk.size() && k < tbl[v].nblk; k++)
            chk($sformatf("v%0d_block%0d", v, k), seen_blk[k], exp_block(k));
         if (seen_blk.size() > 0)
            chk($sformatf("v%0d_last_word15", v), wsel(seen_blk[seen_blk.size()-1], 15), 32'(tbl[v].len * 32));
      end

      // Empty message block layout
      run_msg(0, 32'h0, 1'b0, 1'b0);
      if (seen_blk.size() > 0)
         chk("empty_block_layout", seen_blk[0], {32'h8000_0000, 480'h0});
      else
         chk("empty_block_present", seen_blk.size(), 1);

      // Length 13 fits pad + length in one block
      run_msg(13, 32'h2222_0000, 1'b0, 1'b0);
      chk("len13_blocks", seen_blk.size(), 1);
      if (seen_blk.size() >= 1) begin
         chk("len13_w13", wsel(seen_blk[0], 13), 32'h8000_0000);
         chk("len13_w14", wsel(seen_blk[0], 14), 32'h0);
         chk("len13_w15", wsel(seen_blk[0], 15), 32'h0000_01a0);
      end

      // Length 14 with msg_start and blk_done pulsed during FILL
      run_msg(14, 32'h3333_0000, 1'b0, 1'b1);
      chk("len14_blocks", seen_blk.size(), 2);
      chk("len14_digest", bus.digest, model_digest());
      chk("len14_accepted", acc, 14);
`ifdef SHA256_FEEDER_CNT_EN
      chk("len14_blk_count", bus.blk_count, 2);
`endif
      if (seen_blk.size() >= 2) begin
         chk("len14_b0_w14", wsel(seen_blk[0], 14), 32'h8000_0000);
         chk("len14_b0_w15", wsel(seen_blk[0], 15), 32'h0);
         chk("len14_b1_w0",  wsel(seen_blk[1], 0),  32'h0);
         chk("len14_b1_w14", wsel(seen_blk[1], 14), 32'h0);
         chk("len14_b1_w15", wsel(seen_blk[1], 15), 32'h0000_01c0);
      end

      // Reset in the middle of WAIT, late blk_done afterwards
      core_en = 1'b0;
      @(posedge clk); #1;
      bus.msg_start = 1'b1;
      bus.msg_len   = '0;
      @(posedge clk); #1;
      bus.msg_start = 1'b0;
      waited = 0; seen_start = 1'b0;
      while (!seen_start && waited < 100) begin
         @(posedge clk); #1;
         seen_start = bus.blk_start;
         waited++;
      end
      chk("rst_test_blk_start_seen", seen_start, 1'b1);
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_outputs_zero("midwait_reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      man_done = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b0;
      seen_start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.blk_start) seen_start = 1'b1;
      end
      chk("after_reset_no_blk_start", seen_start, 1'b0);
      check_outputs_zero("after_late_done");
      core_en = 1'b1;
      run_msg(0, 32'h0, 1'b0, 1'b0);
      chk("after_reset_empty_digest", bus.digest, C_DIG_EMPTY);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
